// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if: producer/consumer handshake and status bundle for sync_fifo_flex
interface sync_fifo_flex_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   logic                  wr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  rd;
   logic                  err_clr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  valid;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic [ADDR_W:0]       count;
   logic                  overflow;
   logic                  underflow;
   modport master (
      output wr, wdata, rd, err_clr,
      input  rdata, valid, empty, full, almost_empty, almost_full, count, overflow, underflow
   );
   modport slave (
      input  wr, wdata, rd, err_clr,
      output rdata, valid, empty, full, almost_empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with occupancy, thresholds, standard/FWFT read and error flags
module sync_fifo_flex #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2,
   parameter bit FWFT       = 1'b0,
   parameter bit STICKY_ERR = 1'b0
) (
   input logic             clk,
   input logic             rst_n,
   sync_fifo_flex_if.slave bus
);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0] AF    = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE    = (ADDR_W+1)'(AE_LEVEL);
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
   logic                  empty, full, rd_ok, wr_ok, ovf_ev, unf_ev;
   logic [DATA_WIDTH-1:0] head;
   assign empty  = count_q == '0;
   assign full   = count_q == DEPTH;
   assign rd_ok  = bus.rd & !empty;
   assign wr_ok  = bus.wr & (!full | rd_ok);
   assign ovf_ev = bus.wr & !wr_ok;
   assign unf_ev = bus.rd & empty;
   assign head   = mem[rd_ptr_q[ADDR_W-1:0]];
   // Next state: pointers/count advance only on accepted ops; error flags pulse or latch until cleared
   always_comb begin
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(wr_ok);
      rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(rd_ok);
      count_d  = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
      rdata_d  = rd_ok ? head : rdata_q;
      valid_d  = rd_ok;
      ovf_d    = STICKY_ERR ? (ovf_ev | (ovf_q & !bus.err_clr)) : ovf_ev;
      unf_d    = STICKY_ERR ? (unf_ev | (unf_q & !bus.err_clr)) : unf_ev;
   end
   // State registers; reset empties the FIFO at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end
   // Storage array, deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_q[ADDR_W-1:0]] <= bus.wdata;
   end
   assign bus.rdata        = FWFT ? head : rdata_q;
   assign bus.valid        = FWFT ? !empty : valid_q;
   assign bus.empty        = empty;
   assign bus.full         = full;
   assign bus.almost_empty = count_q <= AE;
   assign bus.almost_full  = count_q >= AF;
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: scoreboard bench driving a standard/pulse FIFO and an FWFT/sticky FIFO in lockstep
module tb_sync_fifo_flex;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
   logic [7:0] wdata = '0;
   int         n_vec = 0, n_err = 0;
   int         m_cnt = 0;
   logic       m_v0 = 0, m_o0 = 0, m_u0 = 0, m_o1 = 0, m_u1 = 0;
   logic [7:0] q0[$], q1[$];

   always #5 clk = ~clk;

   sync_fifo_flex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) b0 ();
   sync_fifo_flex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) b1 ();
   assign b0.wr = wr;  assign b0.wdata = wdata;  assign b0.rd = rd;  assign b0.err_clr = err_clr;
   assign b1.wr = wr;  assign b1.wdata = wdata;  assign b1.rd = rd;  assign b1.err_clr = err_clr;

   sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2),
                    .FWFT(1'b0), .STICKY_ERR(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2),
                    .FWFT(1'b1), .STICKY_ERR(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("count0", 32'(b0.count), m_cnt);
      chk("count1", 32'(b1.count), m_cnt);
      chk("empty", 32'(b0.empty), m_cnt == 0);
      chk("full", 32'(b0.full), m_cnt == 8);
      chk("full1", 32'(b1.full), m_cnt == 8);
      chk("almost_empty", 32'(b0.almost_empty), m_cnt <= 2);
      chk("almost_full", 32'(b0.almost_full), m_cnt >= 6);
      chk("valid0", 32'(b0.valid), m_v0);
      chk("overflow0", 32'(b0.overflow), m_o0);
      chk("underflow0", 32'(b0.underflow), m_u0);
      chk("overflow1", 32'(b1.overflow), m_o1);
      chk("underflow1", 32'(b1.underflow), m_u1);
   endtask

   task automatic model_reset();
      m_cnt = 0; m_v0 = 0; m_o0 = 0; m_u0 = 0; m_o1 = 0; m_u1 = 0;
      q0.delete(); q1.delete();
   endtask

   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
      logic rok, wok, oev, uev;
      wr = w; wdata = d; rd = r; err_clr = c;
      rok = r && m_cnt != 0;
      wok = w && (m_cnt != 8 || rok);
      oev = w && !wok;
      uev = r && m_cnt == 0;
      @(posedge clk);
      if (wok) begin q0.push_back(d); q1.push_back(d); end
      m_cnt = m_cnt + int'(wok) - int'(rok);
      m_v0 = rok; m_o0 = oev; m_u0 = uev;
      m_o1 = oev | (m_o1 & !c);
      m_u1 = uev | (m_u1 & !c);
      #1 check_all();
   endtask

   // Standard-mode monitor: every valid cycle must carry the oldest expected word
   always @(negedge clk) begin
      if (rst_n && b0.valid) begin
         if (q0.size() == 0) chk("std_unexpected_valid", 32'(b0.valid), 0);
         else chk("std_rdata", 32'(b0.rdata), 32'(q0.pop_front()));
      end
   end

   // FWFT monitor: valid tracks occupancy; head word is checked as it is popped
   always @(negedge clk) begin
      if (rst_n) begin
         chk("fwft_valid", 32'(b1.valid), q1.size() != 0);
         if (b1.valid && rd && q1.size() != 0) chk("fwft_rdata", 32'(b1.rdata), 32'(q1.pop_front()));
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check_all();
      chk("fwft_valid_rst", 32'(b1.valid), 0);
      cyc(0, 8'h00, 0, 0);
      // fill 0x01..0x08 then drain
      for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
      // full pass-through, overflow pulse vs sticky, err_clr racing an event
      for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
      cyc(1, 8'hAA, 1, 0);
      cyc(1, 8'hBB, 0, 0);
      cyc(0, 8'h00, 0, 0);
      cyc(1, 8'hCC, 0, 1);
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
      // underflow on empty, empty with simultaneous wr/rd
      cyc(0, 8'h00, 1, 0);
      cyc(1, 8'h77, 1, 0);
      cyc(0, 8'h00, 0, 1);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
      // FWFT: written word visible next cycle without rd
      cyc(1, 8'h5A, 0, 0);
      chk("fwft_5a_valid", 32'(b1.valid), 1);
      chk("fwft_5a_rdata", 32'(b1.rdata), 32'h5A);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
      // interleaved traffic wrapping pointers, then reset mid-stream
      for (int i = 0; i < 20; i++) cyc(1, 8'h40 + 8'(i), i > 0, 0);
      rst_n = 1'b0; wr = 0; rd = 0; err_clr = 0;
      model_reset();
      #1 check_all();
      chk("fwft_valid_midrst", 32'(b1.valid), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(1, 8'h33, 0, 0);
      chk("post_rst_fwft_rdata", 32'(b1.rdata), 32'h33);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
      cyc(0, 8'h00, 0, 0);
      chk("sb0_drained", q0.size(), 0);
      chk("sb1_drained", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
